// File: rtl/service_counter_bank_pkg.sv
// Shared constants, teller FSM encoding and packed-bus helpers for the
// service counter bank and the dispatcher that feeds it.
package service_counter_bank_pkg;

    // Default widths and counts shared with the dispatcher
    localparam int DEF_DT_SZ    = 4;
    localparam int DEF_CNTER    = 3;
    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_SRV_W    = 8;

    // Teller FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } teller_state_t;

    // Low bit index of slice idx in a packed bus of width-wide fields
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/service_counter_bank_teller_unit.sv
// One service teller: loads {customer, service time}, counts the time down
// in units of TICK_DIV clocks, then pulses done with the served customer.
module teller_unit
    import service_counter_bank_pkg::*;
#(
    parameter int DT_SZ    = DEF_DT_SZ,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [DT_SZ-1:0] dn,
    input  logic [DT_SZ-1:0] dt,
    output logic             busy,
    output logic [DT_SZ-1:0] cur_n,
    output logic [DT_SZ-1:0] remain,
    output logic             done,
    output logic [DT_SZ-1:0] done_n,
    output logic             ld_rejected
);

    // A prescaler of width 1 still works when TICK_DIV is 1 (it never leaves 0)
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    teller_state_t   state;
    logic [PS_W-1:0] presc;

    // A load that lands while the teller is serving is dropped and flagged
    assign ld_rejected = ld && (state == SERVE);

    // Teller FSM: idle until loaded, then count service units down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            presc  <= '0;
            busy   <= 1'b0;
            cur_n  <= '0;
            remain <= '0;
            done   <= 1'b0;
            done_n <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        busy   <= 1'b1;
                        cur_n  <= dn;
                        presc  <= '0;
                        remain <= (dt == '0) ? DT_SZ'(1) : dt;
                        state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (presc == PS_LAST) begin
                        presc <= '0;
                        if (remain > DT_SZ'(1)) begin
                            remain <= remain - DT_SZ'(1);
                        end else begin
                            remain <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            done_n <= cur_n;
                            state  <= IDLE;
                        end
                    end else begin
                        presc <= presc + PS_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/service_counter_bank.sv
// Bank of CNTER independent tellers plus the shared served-customer counter
// and the sticky overload flag raised when a busy teller is loaded.
module service_counter_bank
    import service_counter_bank_pkg::*;
#(
    parameter int DT_SZ    = DEF_DT_SZ,
    parameter int CNTER    = DEF_CNTER,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SRV_W    = DEF_SRV_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNTER-1:0]       ld,
    input  logic [CNTER*DT_SZ-1:0] dn,
    input  logic [CNTER*DT_SZ-1:0] dt,
    output logic [CNTER-1:0]       busy,
    output logic [CNTER*DT_SZ-1:0] cur_n,
    output logic [CNTER*DT_SZ-1:0] remain,
    output logic [CNTER-1:0]       done,
    output logic [CNTER*DT_SZ-1:0] done_n,
    output logic [SRV_W-1:0]       served_cnt,
    output logic                   ovr_err
);

    logic [CNTER-1:0] ld_rejected;
    logic [SRV_W-1:0] done_count;

    for (genvar i = 0; i < CNTER; i++) begin : g_teller
        teller_unit #(
            .DT_SZ   (DT_SZ),
            .TICK_DIV(TICK_DIV)
        ) u_teller (
            .clk        (clk),
            .rst        (rst),
            .ld         (ld[i]),
            .dn         (dn[slice_lo(i, DT_SZ) +: DT_SZ]),
            .dt         (dt[slice_lo(i, DT_SZ) +: DT_SZ]),
            .busy       (busy[i]),
            .cur_n      (cur_n[slice_lo(i, DT_SZ) +: DT_SZ]),
            .remain     (remain[slice_lo(i, DT_SZ) +: DT_SZ]),
            .done       (done[i]),
            .done_n     (done_n[slice_lo(i, DT_SZ) +: DT_SZ]),
            .ld_rejected(ld_rejected[i])
        );
    end

    // Number of tellers finishing this cycle
    always_comb begin
        done_count = '0;
        for (int i = 0; i < CNTER; i++) begin
            done_count = done_count + SRV_W'(done[i]);
        end
    end

    // Running total of completed customers, wrapping at 2^SRV_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_cnt <= '0;
        end else begin
            served_cnt <= served_cnt + done_count;
        end
    end

    // Overload flag stays set from the first rejected load until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_err <= 1'b0;
        end else if (|ld_rejected) begin
            ovr_err <= 1'b1;
        end
    end

endmodule

// File: doc/service_counter_bank.md
Name: service_counter_bank

Overview:
- Bank of CNTER service counters (tellers) at the receiving end of the dispatcher's load interface.
- Each teller accepts a one-cycle load pulse with {customer number, service time} and holds busy high while it counts the service time down.
- When the count finishes it drops busy and emits a one-cycle done pulse carrying the served customer number.
- Busy flags feed back to the dispatcher's busy input; done/served outputs feed the display/statistics logic.

Parameters:
DT_SZ, 4, width of customer number and service time fields
CNTER, 3, number of tellers
TICK_DIV, 4, clock cycles per service-time unit (>=1)
SRV_W, 8, width of total-served counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ld  in  CNTER  load pulse per teller, one clk high, from dispatcher
dn  in  CNTER*DT_SZ  packed customer numbers; slice i = dn[i*DT_SZ +: DT_SZ]
dt  in  CNTER*DT_SZ  packed service times, same packing
busy  out  CNTER  teller i currently serving
cur_n  out  CNTER*DT_SZ  number being served (holds last value when idle)
remain  out  CNTER*DT_SZ  remaining service units, 0 when idle
done  out  CNTER  one-cycle pulse: teller i finished a customer
done_n  out  CNTER*DT_SZ  number just finished; valid while done[i]=1, held otherwise
served_cnt  out  SRV_W  total customers completed since reset
ovr_err  out  1  sticky: ld arrived for a busy teller

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every output is 0: busy, cur_n, remain, done, done_n, served_cnt, ovr_err. All per-teller prescalers are also 0.
- Reset asserted mid-service aborts service immediately. No done pulse is emitted.
- Each teller runs a 2-state FSM, IDLE and SERVE, all registered. Tellers are fully independent of each other.
- IDLE, ld[i]=1 sampled at edge E:
  - busy←1, cur_n←dn slice, prescaler←0.
  - remain←dt slice. If dt=0, remain←1 (minimum one unit).
  - Go to SERVE.
- SERVE, every cycle: the prescaler increments. When the prescaler = TICK_DIV-1:
  - prescaler←0.
  - If remain>1: remain←remain-1.
  - If remain=1: remain←0, busy←0, done[i]←1, done_n slice←cur_n, go to IDLE.
- Timing result: busy is high for exactly max(dt,1)*TICK_DIV cycles, from edge E to edge E+max(dt,1)*TICK_DIV. done[i] rises at the same edge busy falls.
- done[i] defaults to 0 every cycle, so it is a single-cycle pulse.
- Earliest reload: the dispatcher sees busy=0 in the cycle after the finishing edge. A ld in that cycle is accepted normally. There is no dead cycle beyond the registered busy.
- ld[i]=1 while busy[i]=1 (before the finishing edge):
  - The load is ignored; the in-progress service is unaffected.
  - ovr_err←1, which stays set until reset.
  - This includes ld on the very edge where service finishes, because busy was still 1.
- Load-to-busy latency is 1 cycle. The dispatcher's back-to-back inhibit covers this window; the bank does not rely on it.
- served_cnt adds popcount(done) at each edge.
  - Multiple simultaneous completions add together.
  - The counter wraps modulo 2^SRV_W.
  - The increment is visible the edge after the done pulse.
- Multiple ld bits set in one cycle are legal; each teller loads independently.
- All arithmetic is unsigned. remain never underflows because it is floored at 0.

Decomposition:
- Shared package holds: DT_SZ, CNTER and TICK_DIV defaults; FSM state encoding (IDLE=0, SERVE=1); the slice-index helper for packed buses. The dispatcher uses the same constants.
- One sub-module, teller_unit: a single teller's FSM, prescaler and remain counter. It is instantiated CNTER times by a generate loop.
- The top level contains only the instances, popcount/served_cnt and ovr_err aggregation.

Test Plan:
1. Reset release, no loads for 20 cycles -> all outputs stay 0.
2. TICK_DIV=4: ld=3'b001, dn[3:0]=5, dt[3:0]=3 at edge E -> busy[0]=1 from E for 12 cycles. remain goes 3,2,1 at 4-cycle steps. At E+12: busy[0]=0, done[0]=1 for one cycle, done_n[3:0]=5. served_cnt=1 the following edge.
3. dt=0 on teller 1 -> busy[1] high for exactly 4 cycles, then done[1] pulse. remain reads 1, then 0.
4. Teller 0 and teller 2 loaded the same cycle with dt=2 -> both done pulses coincide at E+8. served_cnt increments by 2 in one step.
5. ld[0] pulsed mid-service, and again on its finishing edge -> cur_n/remain unchanged, done timing unchanged, ovr_err=1 sticky. A ld the cycle after done is accepted and ovr_err stays 1.
6. rst asserted asynchronously mid-service (between edges) -> outputs go 0 immediately with no done pulse. After release, a new load behaves as in scenario 2.
